image_uart_tx: RTL and testbench
================================

IMAGE_UART_TX -- requirements
Module: image_uart_tx

Interface
REQ-001 SHALL have parameter IMAGE_SIZE, default 307200 (640*480*1), number of bytes sent per frame.
REQ-002 SHALL have parameter TX_BASE, default 4, UART transmit-data register byte address.
REQ-003 SHALL have parameter STATUS_BASE, default 8, UART status register byte address.
REQ-004 SHALL have parameter TX_OK_BIT, default 6, status bit meaning the transmitter accepts a byte.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 avm_clk  in  1  sole clock, all logic on rising edge.
REQ-007 avm_rst  in  1  synchronous active-high reset.
REQ-008 avm_address  out  5  Avalon-MM address.
REQ-009 avm_read  out  1  Avalon-MM read strobe.
REQ-010 avm_write  out  1  Avalon-MM write strobe.
REQ-011 avm_writedata  out  32  Avalon-MM write data.
REQ-012 avm_readdata  in  32  Avalon-MM read data, valid when avm_read=1 and avm_waitrequest=0.
REQ-013 avm_waitrequest  in  1  slave stall; the current transfer completes on the first cycle it is 0.
REQ-014 sram_req  out  1  pixel read request.
REQ-015 sram_addr  out  20  pixel address.
REQ-016 sram_rdata  in  8  pixel byte, valid when sram_ack=1.
REQ-017 sram_ack  in  1  one-cycle read-complete strobe.
REQ-018 start  in  1  begin sending a frame; sampled only in S_IDLE.
REQ-019 busy  out  1  frame transfer in progress.
REQ-020 send_finish  out  1  one-cycle pulse after the last byte's write completes.

Function
REQ-021 All outputs SHALL be registered.
REQ-022 States: S_IDLE, S_FETCH, S_POLL, S_SEND, S_DONE.
REQ-023 S_IDLE: read=write=req=0. start=1 -> S_FETCH, byte counter=0, busy=1 on the next cycle.
REQ-024 S_FETCH: sram_req=1 with sram_addr=counter. On sram_ack: latch sram_rdata, drop req, set avm_read=1 and avm_address=STATUS_BASE, go to S_POLL.
REQ-025 S_POLL: read held until waitrequest=0.
- Bit TX_OK_BIT set: read=0, write=1, address=TX_BASE, writedata={24'b0,byte}, go to S_SEND.
- Bit clear: read stays 1 and re-polls with no idle cycle.
REQ-026 S_SEND: write, address and writedata held stable while waitrequest=1. On waitrequest=0: write=0, counter+1.
- New counter == IMAGE_SIZE -> S_DONE.
- Otherwise -> S_FETCH.
REQ-027 S_DONE: send_finish=1 and busy=0 for exactly one cycle, then S_IDLE.
REQ-028 avm_read and avm_write SHALL never both be 1; sram_req SHALL never be 1 while either is 1.
REQ-029 Byte counter and sram_addr are 20 bits; the largest value used is IMAGE_SIZE-1 (IMAGE_SIZE <= 2^20); no wrap.
REQ-030 start while busy=1 SHALL be ignored; start during the S_DONE cycle SHALL be ignored.
REQ-031 Bytes SHALL be sent in ascending address order from 0; no byte skipped or repeated.
REQ-032 sram_ack outside S_FETCH SHALL be ignored.

Reset
REQ-033 With avm_rst=1 at a clock edge:
- state=S_IDLE, counter=0, latched byte=0.
- avm_address=STATUS_BASE, read=write=0, writedata=0.
- sram_req=0, sram_addr=0, busy=0, send_finish=0.
REQ-034 Reset mid-frame SHALL abandon the transfer immediately (any pending Avalon or SRAM request dropped); no send_finish.

Verification
REQ-035 IMAGE_SIZE=4, SRAM bytes 0x11,0x22,0x33,0x44, status always 0x40, waitrequest=0 -> writes 0x11,0x22,0x33,0x44 to address 4 in order; one send_finish pulse; busy low afterwards.
REQ-036 Status returns 0x00 for 5 polls, then 0x40 -> 6 reads at address 8, then 1 write; no write before bit 6 is seen.
REQ-037 waitrequest=1 for 3 cycles during a write of 0xA5 -> write, address 4 and writedata 0x000000A5 stable for 4 cycles; counter increments once.
REQ-038 Reset asserted in S_SEND after 2 of 4 bytes -> next cycle all outputs at reset values; a new start resends from address 0.
REQ-039 start held high for a full 4-byte frame -> exactly one frame sent; a second frame begins only after S_IDLE is re-entered with start=1.
REQ-040 Default IMAGE_SIZE, random waitrequest/ack delays -> exactly 307200 writes; last sram_addr=307199; single send_finish.

Source files
------------

// File: rtl/image_uart_tx.sv
// Streams IMAGE_SIZE bytes from pixel SRAM to a UART over Avalon-MM,
// polling the UART status register before every transmit write.
`timescale 1ns/1ps
module image_uart_tx #(
  parameter int IMAGE_SIZE  = 307200,
  parameter int TX_BASE     = 4,
  parameter int STATUS_BASE = 8,
  parameter int TX_OK_BIT   = 6
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        sram_req,
  output logic [19:0] sram_addr,
  input  logic [7:0]  sram_rdata,
  input  logic        sram_ack,
  input  logic        start,
  output logic        busy,
  output logic        send_finish
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_POLL, S_SEND, S_DONE} state_t;

  localparam logic [4:0]  TX_ADDR     = 5'(TX_BASE);
  localparam logic [4:0]  STATUS_ADDR = 5'(STATUS_BASE);
  localparam logic [20:0] LAST_COUNT  = 21'(IMAGE_SIZE);

  state_t      state;
  logic [19:0] byte_cnt;
  logic [7:0]  pix_byte;
  logic [20:0] cnt_next;
  logic        unused_rdata;

  // One extra bit so a full 2^20-byte frame still terminates.
  assign cnt_next     = {1'b0, byte_cnt} + 21'd1;
  assign unused_rdata = ^avm_readdata;

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      state         <= S_IDLE;
      byte_cnt      <= '0;
      pix_byte      <= '0;
      avm_address   <= STATUS_ADDR;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      sram_req      <= 1'b0;
      sram_addr     <= '0;
      busy          <= 1'b0;
      send_finish   <= 1'b0;
    end else begin
      send_finish <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            byte_cnt  <= '0;
            sram_addr <= '0;
            sram_req  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_FETCH: begin
          if (sram_ack) begin
            pix_byte    <= sram_rdata;
            sram_req    <= 1'b0;
            avm_read    <= 1'b1;
            avm_address <= STATUS_ADDR;
            state       <= S_POLL;
          end
        end
        S_POLL: begin
          // A clear ready bit leaves the read asserted, so polling repeats back to back.
          if (!avm_waitrequest && avm_readdata[TX_OK_BIT]) begin
            avm_read      <= 1'b0;
            avm_write     <= 1'b1;
            avm_address   <= TX_ADDR;
            avm_writedata <= {24'b0, pix_byte};
            state         <= S_SEND;
          end
        end
        S_SEND: begin
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            byte_cnt  <= cnt_next[19:0];
            if (cnt_next == LAST_COUNT) begin
              state       <= S_DONE;
              busy        <= 1'b0;
              send_finish <= 1'b1;
            end else begin
              state     <= S_FETCH;
              sram_req  <= 1'b1;
              sram_addr <= cnt_next[19:0];
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_uart_tx.sv
// Bench for image_uart_tx: SRAM and UART slave models, a frame-level scoreboard
// and a monitor that checks every completed Avalon transfer against it.
`timescale 1ns/1ps
module tb_image_uart_tx;
  localparam int N = 4;

  logic        avm_clk = 1'b0;
  logic        avm_rst = 1'b1;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_waitrequest = 1'b0;
  logic        sram_req;
  logic [19:0] sram_addr;
  logic [7:0]  sram_rdata = 8'h0;
  logic        sram_ack = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        send_finish;

  image_uart_tx #(.IMAGE_SIZE(N), .TX_BASE(4), .STATUS_BASE(8), .TX_OK_BIT(6)) dut (
    .avm_clk(avm_clk), .avm_rst(avm_rst), .avm_address(avm_address),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .sram_req(sram_req), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .sram_ack(sram_ack), .start(start), .busy(busy), .send_finish(send_finish)
  );

  always #5 avm_clk = ~avm_clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Environment configuration
  logic [7:0] mem [N];
  bit wr_rand = 0, status_rand = 0, spur_ack = 0;
  int nok_cfg = 0, nok_left = 0, hold_wr = 0;

  // Scoreboard state
  logic [7:0] exp_q[$];
  int rd_hist[$];
  int wl_hist[$];
  int fin_cnt = 0, frame_writes = 0, reads_since = 0, wr_len = 0;
  bit ok_seen = 0, prev_wwait = 0, prev_rwait = 0, prev_fin = 0;
  logic [4:0]  prev_addr;
  logic [31:0] prev_data;
  logic [7:0]  e;

  // SRAM: random ack latency, occasional stray acks while no request is pending
  initial begin
    int wt;
    wt = 0;
    forever begin
      @(posedge avm_clk); #1;
      if (sram_ack) sram_ack = 1'b0;
      else if (sram_req) begin
        if (wt == 0) begin
          sram_ack   = 1'b1;
          sram_rdata = mem[int'(sram_addr) % N];
          wt = $urandom_range(0, 3);
        end else wt--;
      end else if (spur_ack && $urandom_range(0, 7) == 0) begin
        sram_ack   = 1'b1;
        sram_rdata = 8'($urandom);
      end
    end
  end

  // UART slave: waitrequest and status register
  initial begin
    forever begin
      @(posedge avm_clk); #1;
      if (avm_write && hold_wr > 0) begin
        avm_waitrequest = 1'b1;
        hold_wr--;
      end else avm_waitrequest = wr_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (nok_left > 0) avm_readdata = 32'h0;
      else if (status_rand) avm_readdata = $urandom;
      else avm_readdata = 32'h40;
    end
  end

  // Monitor: judges what completes at the coming rising edge
  initial begin
    forever begin
      @(negedge avm_clk);
      if (avm_rst) begin
        frame_writes = 0; ok_seen = 0; reads_since = 0; wr_len = 0;
        prev_wwait = 0; prev_rwait = 0; prev_fin = 0; nok_left = nok_cfg;
      end else begin
        check("rd_wr_excl", 64'(avm_read & avm_write), 64'd0);
        check("req_excl", 64'(sram_req & (avm_read | avm_write)), 64'd0);
        if (prev_wwait)
          check("wr_hold", {avm_write, avm_address, avm_writedata}, {1'b1, prev_addr, prev_data});
        if (prev_rwait)
          check("rd_hold", {avm_read, avm_address}, {1'b1, 5'd8});
        if (avm_write) wr_len++;
        if (sram_req && sram_ack) check("fetch_addr", 64'(sram_addr), 64'(frame_writes));
        if (avm_read && !avm_waitrequest) begin
          check("rd_addr", 64'(avm_address), 64'd8);
          reads_since++;
          ok_seen = avm_readdata[6];
          if (nok_left > 0) nok_left--;
        end
        if (avm_write && !avm_waitrequest) begin
          check("wr_after_ok", 64'(ok_seen), 64'd1);
          if (exp_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL wr_extra: got write %0h expected no write", avm_writedata);
          end else begin
            e = exp_q.pop_front();
            check("wr_data", {avm_address, avm_writedata}, {5'd4, 24'd0, e});
          end
          rd_hist.push_back(reads_since);
          wl_hist.push_back(wr_len);
          reads_since = 0; wr_len = 0; ok_seen = 0; frame_writes++; nok_left = nok_cfg;
        end
        if (send_finish) begin
          fin_cnt++;
          check("fin_pulse", {prev_fin, busy, exp_q.size() == 0, frame_writes == N}, 64'b0011);
          frame_writes = 0;
        end
        prev_wwait = avm_write && avm_waitrequest;
        prev_rwait = avm_read && avm_waitrequest;
        prev_addr  = avm_address;
        prev_data  = avm_writedata;
        prev_fin   = send_finish;
      end
    end
  end

  task automatic tick();
    @(posedge avm_clk); #1;
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {avm_address, avm_read, avm_write, avm_writedata, sram_req, sram_addr, busy, send_finish},
          {5'd8, 1'b0, 1'b0, 32'd0, 1'b0, 20'd0, 1'b0, 1'b0});
  endtask

  task automatic run_frame(input bit hold_start, input bit poke_busy);
    int target;
    int cyc;
    target = fin_cnt + 1;
    cyc = 0;
    for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
    start = 1'b1;
    tick();
    check("busy_rise", 64'(busy), 64'd1);
    if (!hold_start) start = 1'b0;
    while (fin_cnt < target && cyc < 3000) begin
      if (poke_busy && !hold_start) start = busy && ($urandom_range(0, 9) == 0);
      tick();
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 3000) begin
      n_checks++; n_err++;
      $display("FAIL frame_timeout: got %0d finishes expected %0d", fin_cnt, target);
    end
    repeat (8) tick();
    check("idle_after", {busy, sram_req, avm_read, avm_write, exp_q.size() == 0, 32'(fin_cnt)},
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'(target)});
  endtask

  initial begin
    int cyc;
    int f;
    #500000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int f;
    repeat (3) tick();
    check_reset_vals("reset");
    avm_rst = 1'b0;

    // Basic frame
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    run_frame(0, 0);

    // Five not-ready polls before each byte
    nok_cfg = 5; nok_left = 5;
    rd_hist.delete();
    run_frame(0, 0);
    for (int i = 0; i < N; i++) check("poll_count", 64'(rd_hist[i]), 64'd6);
    nok_cfg = 0; nok_left = 0;

    // Write stalled three cycles
    mem[0] = 8'hA5;
    hold_wr = 3;
    wl_hist.delete();
    run_frame(0, 0);
    check("wr_len_stall", 64'(wl_hist[0]), 64'd4);

    // Reset while the third byte is being written
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
    start = 1'b1; tick(); start = 1'b0;
    cyc = 0;
    while (!(frame_writes == 2 && avm_write) && cyc < 2000) begin
      tick(); cyc++;
    end
    if (cyc >= 2000) begin
      n_checks++; n_err++;
      $display("FAIL abort_wait: got %0d writes expected 2", frame_writes);
    end
    avm_rst = 1'b1;
    tick();
    check_reset_vals("reset_mid");
    avm_rst = 1'b0;
    exp_q.delete();
    f = fin_cnt;
    repeat (5) tick();
    check("no_fin_abort", 64'(fin_cnt), 64'(f));
    run_frame(0, 0);

    // start held across the whole frame and the done cycle
    run_frame(1, 0);

    // Randomized frames with stalls, random status, stray acks and stray starts
    wr_rand = 1; status_rand = 1; spur_ack = 1;
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
      run_frame(0, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
